// File: rtl/hs_rx_pkg.sv
// Shared types and constants for the D-PHY HS receive byte aligner.
package hs_rx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WIN_W  = 2 * BYTE_W;
  localparam int unsigned OFFS_W = 3;
  localparam int unsigned K_W    = 4;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    STREAM = 2'd2
  } state_t;

  typedef struct packed {
    logic           hit;
    logic [K_W-1:0] k;
  } sync_match_t;

  // Scan offsets high to low so the lowest matching offset is the one kept.
  function automatic sync_match_t sync_match(input logic [WIN_W-1:0]  w,
                                             input logic [BYTE_W-1:0] pattern);
    sync_match_t r;
    r.hit = 1'b0;
    r.k   = '0;
    for (int k = int'(BYTE_W); k >= 1; k--) begin
      if (w[k +: BYTE_W] == pattern) begin
        r.hit = 1'b1;
        r.k   = K_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hs_rx_byte_aligner_if.sv
// PPI-side signal bundle between the HS deserialiser front end and the aligner.
interface hs_rx_byte_aligner_if;
  import hs_rx_pkg::*;

  logic              Enable;
  logic [BYTE_W-1:0] DataHS;
  logic              RxSyncHS;
  logic [BYTE_W-1:0] RxDataHS;
  logic              RxValidHS;
  logic              RxActiveHS;
  logic [OFFS_W-1:0] AlignOffset;
  logic              ErrSotSyncHS;

  modport master (
    output Enable, DataHS, RxSyncHS,
    input  RxDataHS, RxValidHS, RxActiveHS, AlignOffset, ErrSotSyncHS
  );

  modport slave (
    input  Enable, DataHS, RxSyncHS,
    output RxDataHS, RxValidHS, RxActiveHS, AlignOffset, ErrSotSyncHS
  );

endinterface

// File: rtl/hs_trail_delay_line.sv
// Fixed-depth byte delay line with per-slot valid bits; whatever is still inside
// when the burst ends is the HS trail and gets flushed.
module hs_trail_delay_line
  import hs_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data
);

  logic [DEPTH-1:0]  vld_q;
  logic [BYTE_W-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_valid;
      data_q[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/hs_rx_byte_aligner.sv
// Locks onto the HS sync byte bit offset, realigns the burst and withholds the
// trailing TRAIL_BYTES bytes so HS-trail never reaches the PPI.
module hs_rx_byte_aligner
  import hs_rx_pkg::*;
#(
  parameter int unsigned TRAIL_BYTES = 2
) (
  input logic                 RxByteClkHS,
  input logic                 Rst,
  hs_rx_byte_aligner_if.slave bus
);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] d1_q, d2_q;

  logic [BYTE_W-1:0] data_q;
  logic              valid_q, active_q, err_q;
  logic [OFFS_W-1:0] offset_q;

  logic [BYTE_W-1:0] data_d;
  logic              valid_d, active_d, err_d;
  logic [OFFS_W-1:0] offset_d;

  sync_match_t       match_c;
  logic              lock_c, err_c, push_c, flush_c;
  logic [K_W-1:0]    k_c;
  logic [BYTE_W-1:0] aligned_c;
  logic              dl_valid_c;
  logic [BYTE_W-1:0] dl_data_c;

  assign match_c = sync_match({d1_q, d2_q}, SYNC_BYTE);
  assign flush_c = ~bus.Enable;

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d  = state_q;
    lock_c   = 1'b0;
    err_c    = 1'b0;
    push_c   = 1'b0;
    k_c      = K_W'(BYTE_W);
    data_d   = '0;
    valid_d  = 1'b0;
    active_d = 1'b0;
    offset_d = offset_q;
    err_d    = 1'b0;

    if (state_q == HUNT && bus.Enable && bus.RxSyncHS) begin
      lock_c = match_c.hit;
      err_c  = ~match_c.hit;
    end

    // Offset code 0 stands for a full-byte shift.
    if (lock_c) begin
      k_c = match_c.k;
    end else if (offset_q != '0) begin
      k_c = K_W'(offset_q);
    end
    aligned_c = BYTE_W'({bus.DataHS, d1_q} >> k_c);

    push_c = bus.Enable && (lock_c || state_q == STREAM);

    case (state_q)
      IDLE:    if (bus.Enable) state_d = HUNT;
      HUNT:    if (lock_c) state_d = STREAM;
      STREAM:  state_d = STREAM;
      default: state_d = IDLE;
    endcase
    if (!bus.Enable) state_d = IDLE;

    active_d = push_c;
    valid_d  = bus.Enable && dl_valid_c;
    data_d   = valid_d ? dl_data_c : '0;
    if (lock_c) offset_d = match_c.k[OFFS_W-1:0];
    err_d    = err_c;
  end

  always_ff @(posedge RxByteClkHS) begin
    if (Rst) begin
      state_q  <= IDLE;
      d1_q     <= '0;
      d2_q     <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      offset_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      d1_q     <= bus.DataHS;
      d2_q     <= d1_q;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      offset_q <= offset_d;
      err_q    <= err_d;
    end
  end

  hs_trail_delay_line #(
    .DEPTH (TRAIL_BYTES)
  ) u_trail (
    .clk       (RxByteClkHS),
    .rst       (Rst),
    .flush     (flush_c),
    .in_valid  (push_c),
    .in_data   (aligned_c),
    .out_valid (dl_valid_c),
    .out_data  (dl_data_c)
  );

  assign bus.RxDataHS     = data_q;
  assign bus.RxValidHS    = valid_q;
  assign bus.RxActiveHS   = active_q;
  assign bus.AlignOffset  = offset_q;
  assign bus.ErrSotSyncHS = err_q;

endmodule
